ili9341_spi_receiver: RTL and testbench
=======================================

Name: ili9341_spi_receiver

Overview:
- Slave-side decoder for the ILI9341 4-wire SPI stream (SCK, MOSI, CS, DC) that our display top produces.
- Oversamples the SPI pins on the fast system clock and assembles bytes MSB-first.
- Tracks CASET/PASET address windows and RAMWR pixel streams, and emits one pixel-write strobe per RGB565 pixel with its (x,y) coordinate.
- Used as a display model in simulation, and as an on-chip bus monitor that checks frames sent to the panel.

Parameters:
- H_RES, 240, panel columns; reset value of the column window end is H_RES-1.
- V_RES, 320, panel rows; reset value of the page window end is V_RES-1.
- COORD_W, 9, width of the x/y coordinate outputs and window registers.
- SYNC_STAGES, 2, synchronizer flops on each SPI input (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x the SPI SCK frequency.
- rst  in  1  asynchronous, active-low reset.
- spi_sck  in  1  SPI clock, idle low; MOSI is sampled on the rising edge.
- spi_mosi  in  1  serial data, MSB first.
- spi_cs  in  1  chip select, active low.
- spi_dc  in  1  0 = command byte, 1 = data byte; sampled with the 8th bit.
- cmd_valid  out  1  one-cycle pulse when a command byte completes.
- cmd_code  out  8  last command byte; held until the next command.
- pixel_valid  out  1  one-cycle pulse per completed RAMWR pixel.
- pixel_data  out  16  RGB565 pixel, first byte in [15:8].
- pixel_x  out  COORD_W  column of the current pixel.
- pixel_y  out  COORD_W  row of the current pixel.
- frame_done  out  1  pulse coincident with pixel_valid for the pixel at (EC,EP).

Behaviour:
- Reset (rst low, asynchronous):
  - Outputs: cmd_valid, pixel_valid and frame_done are 0; cmd_code, pixel_data, pixel_x and pixel_y are 0.
  - Window: SC=0, EC=H_RES-1, SP=0, EP=V_RES-1.
  - Decoder in IDLE; bit count and synchronizers cleared.
- Input path:
  - All four SPI inputs pass through SYNC_STAGES flops.
  - SCK rising edge is detected when the synchronized SCK is 1 and was 0 on the previous cycle.
  - A bit is shifted in only if synchronized CS is 0.
- Byte assembly:
  - A 3-bit counter is cleared whenever synchronized CS is 1, so a partial byte is discarded.
  - On the 8th edge the byte is complete, tagged with DC from that same edge, and the counter returns to 0.
- Output latency: every output pulse is registered. It is asserted exactly SYNC_STAGES+2 clk cycles after the pin-level SCK rising edge of the completing bit.
- Decoder FSM, states IDLE, CASET, PASET, RAMWR, OTHER:
  - A command byte from any state:
    - cmd_valid pulses and cmd_code is updated.
    - 0x2A goes to CASET with param index 0; 0x2B goes to PASET with param index 0.
    - 0x2C goes to RAMWR, sets the pointer to (SC,SP) and clears the pixel high-byte flag.
    - Any other value goes to OTHER.
  - CASET/PASET, data bytes:
    - Params 0..3 are collected as start[15:8], start[7:0], end[15:8], end[7:0].
    - Only on the 4th byte, commit start and end, truncated to COORD_W, then go to IDLE.
    - If end < start, commit end = start.
    - A new command before the 4th byte abandons the update; the old window is kept.
  - RAMWR, data bytes:
    - The first byte of a pair is stored as the high byte.
    - The second byte completes the pixel: pixel_valid pulses with pixel_data, pixel_x and pixel_y set to the current pointer.
    - After each pixel, x increments. When x = EC, x wraps to SC and y increments. When x = EC and y = EP, the pointer wraps to (SC,SP) and frame_done pulses with that pixel.
  - OTHER and IDLE: data bytes are ignored.
- CS deassertion never changes FSM state, pointer or the stored high byte. Only the partial byte is lost, so a pixel may straddle CS toggles at a byte boundary.
- pixel_x, pixel_y and pixel_data hold their values between pulses. cmd_valid and pixel_valid never assert in the same cycle.

Test Plan:
- Reset check: hold rst low, toggle SCK with CS low, release rst. All pulses must stay 0, and RAMWR followed by one pixel 0x1234 must give pixel_valid at (0,0) with data 0x1234.
- Window stream: send 0x2A {00,05,00,07}, 0x2B {00,02,00,03}, 0x2C, then 7 pixels F800,07E0,001F,FFFF,0000,FFE0,780F.
  - Coordinates must be (5,2),(6,2),(7,2),(5,3),(6,3),(7,3),(5,2).
  - frame_done pulses only with pixel 6 (0xFFE0).
  - cmd_valid pulses 3 times with cmd_code 2A, 2B, 2C.
- Partial byte: CS low for 5 bits, CS high, then a full 0x2C with DC=0. cmd_code must be 0x2C, with no stray pixel or command.
- Aborted CASET: send 0x2A {00,0A}, then 0x2C and 1 pixel. The pixel must be at (0,0) and the window must be unchanged.
- Reversed window: send 0x2A {00,09,00,04}, 0x2B {00,00,00,00}, 0x2C, 2 pixels. Both pixels must be at (9,0), each with frame_done.
- Async reset mid-RAMWR: pull rst low between the two bytes of a pixel with no clk edge. All outputs must be 0 immediately, the next data byte must produce no pixel, and the window must return to defaults.

Source files
------------

// File: rtl/ili9341_spi_receiver.sv
// ILI9341 4-wire SPI slave decoder: oversamples SCK/MOSI/CS/DC, assembles bytes and
// tracks CASET/PASET windows to emit one strobe per RAMWR RGB565 pixel with its coordinate.
module ili9341_spi_receiver #(
  parameter int unsigned H_RES       = 240,
  parameter int unsigned V_RES       = 320,
  parameter int unsigned COORD_W     = 9,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  input  logic               spi_cs,
  input  logic               spi_dc,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               pixel_valid,
  output logic [15:0]        pixel_data,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_done
);

  localparam logic [COORD_W-1:0] EcRst = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] EpRst = COORD_W'(V_RES - 1);

  typedef enum logic [2:0] {StIdle, StCaset, StPaset, StRamwr, StOther} state_e;

  // Input synchronizers
  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q, dc_sync_q;
  logic sck_s, mosi_s, cs_s, dc_s, sck_prev_q, sck_rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      dc_sync_q   <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
      sck_prev_q  <= sck_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;

  // Byte assembly; a CS-high cycle discards any partial byte
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       byte_dc_q, byte_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_dc_q    <= 1'b0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q       <= {shift_q, mosi_s};
          byte_dc_q    <= dc_s;
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  // Decoder state
  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [7:0]         par0_q, par0_d, par1_q, par1_d, par2_q, par2_d;
  logic [COORD_W-1:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               hi_flag_q, hi_flag_d;
  logic [7:0]         hi_byte_q, hi_byte_d;
  logic               cmd_valid_q, cmd_valid_d, pixel_valid_q, pixel_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         cmd_code_q, cmd_code_d;
  logic [15:0]        pixel_data_q, pixel_data_d;
  logic [COORD_W-1:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      par0_q        <= '0;
      par1_q        <= '0;
      par2_q        <= '0;
      sc_q          <= '0;
      ec_q          <= EcRst;
      sp_q          <= '0;
      ep_q          <= EpRst;
      x_q           <= '0;
      y_q           <= '0;
      hi_flag_q     <= 1'b0;
      hi_byte_q     <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= '0;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      par0_q        <= par0_d;
      par1_q        <= par1_d;
      par2_q        <= par2_d;
      sc_q          <= sc_d;
      ec_q          <= ec_d;
      sp_q          <= sp_d;
      ep_q          <= ep_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hi_flag_q     <= hi_flag_d;
      hi_byte_q     <= hi_byte_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Window commit values from the four collected parameter bytes
  logic [15:0]        par_start, par_end;
  logic [COORD_W-1:0] new_start, new_end;

  always_comb begin
    par_start = {par0_q, par1_q};
    par_end   = {par2_q, byte_q};
    new_start = par_start[COORD_W-1:0];
    new_end   = par_end[COORD_W-1:0];
    if (new_end < new_start) new_end = new_start;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    par0_d        = par0_q;
    par1_d        = par1_q;
    par2_d        = par2_q;
    sc_d          = sc_q;
    ec_d          = ec_q;
    sp_d          = sp_q;
    ep_d          = ep_q;
    x_d           = x_q;
    y_d           = y_q;
    hi_flag_d     = hi_flag_q;
    hi_byte_d     = hi_byte_q;
    cmd_valid_d   = 1'b0;
    cmd_code_d    = cmd_code_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    frame_done_d  = 1'b0;

    if (byte_valid_q && !byte_dc_q) begin
      cmd_valid_d = 1'b1;
      cmd_code_d  = byte_q;
      idx_d       = '0;
      unique case (byte_q)
        8'h2A:   state_d = StCaset;
        8'h2B:   state_d = StPaset;
        8'h2C: begin
          state_d   = StRamwr;
          x_d       = sc_q;
          y_d       = sp_q;
          hi_flag_d = 1'b0;
        end
        default: state_d = StOther;
      endcase
    end else if (byte_valid_q) begin
      unique case (state_q)
        StCaset, StPaset: begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: par0_d = byte_q;
            2'd1: par1_d = byte_q;
            2'd2: par2_d = byte_q;
            default: begin
              state_d = StIdle;
              if (state_q == StCaset) begin
                sc_d = new_start;
                ec_d = new_end;
              end else begin
                sp_d = new_start;
                ep_d = new_end;
              end
            end
          endcase
        end
        StRamwr: begin
          if (!hi_flag_q) begin
            hi_byte_d = byte_q;
            hi_flag_d = 1'b1;
          end else begin
            hi_flag_d     = 1'b0;
            pixel_valid_d = 1'b1;
            pixel_data_d  = {hi_byte_q, byte_q};
            pixel_x_d     = x_q;
            pixel_y_d     = y_q;
            if (x_q == ec_q) begin
              x_d = sc_q;
              if (y_q == ep_q) begin
                y_d          = sp_q;
                frame_done_d = 1'b1;
              end else begin
                y_d = y_q + COORD_W'(1);
              end
            end else begin
              x_d = x_q + COORD_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_data  = pixel_data_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ili9341_spi_receiver.sv
// Bench for ili9341_spi_receiver: drives SPI bytes and compares pixel/command events
// against a window-index reference model.
module tb_ili9341_spi_receiver;
  localparam int COORD_W = 9;
  localparam int SYNC    = 2;
  localparam int HRES    = 240;
  localparam int VRES    = 320;

  logic clk = 1'b0, rst = 1'b0, sck = 1'b0, mosi = 1'b0, cs = 1'b1, dc = 1'b0;
  logic               cmd_valid, pixel_valid, frame_done;
  logic [7:0]         cmd_code;
  logic [15:0]        pixel_data;
  logic [COORD_W-1:0] pixel_x, pixel_y;

  always #5 clk = ~clk;

  ili9341_spi_receiver #(
    .H_RES(HRES), .V_RES(VRES), .COORD_W(COORD_W), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs), .spi_dc(dc),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pixel_valid(pixel_valid),
    .pixel_data(pixel_data), .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_done(frame_done)
  );

  typedef struct packed {int x; int y; int d; int fd;} pix_t;
  pix_t obs_pix[$], exp_pix[$];
  int   obs_cmd[$], exp_cmd[$];
  int   total = 0, bad = 0, collisions = 0, stray_fd = 0;

  always @(negedge clk) if (rst) begin
    if (pixel_valid)
      obs_pix.push_back('{int'(pixel_x), int'(pixel_y), int'(pixel_data), int'(frame_done)});
    if (frame_done && !pixel_valid) stray_fd++;
    if (cmd_valid) obs_cmd.push_back(int'(cmd_code));
    if (cmd_valid && pixel_valid) collisions++;
  end

  // Reference model: pointer derived from a pixel index within the window
  int m_sc, m_ec, m_sp, m_ep, m_mode, m_pcnt, m_hi, m_have_hi, m_n;
  int m_par[4];

  task automatic model_reset();
    m_sc = 0; m_ec = HRES - 1; m_sp = 0; m_ep = VRES - 1;
    m_mode = 0; m_pcnt = 0; m_have_hi = 0; m_n = 0; m_hi = 0;
  endtask

  task automatic model_byte(input int isdata, input int b);
    int s, e, w, h, x, y;
    if (isdata == 0) begin
      exp_cmd.push_back(b);
      m_pcnt = 0; m_have_hi = 0; m_n = 0;
      case (b)
        'h2A: m_mode = 1;
        'h2B: m_mode = 2;
        'h2C: m_mode = 3;
        default: m_mode = 4;
      endcase
    end else if (m_mode == 1 || m_mode == 2) begin
      m_par[m_pcnt] = b;
      m_pcnt++;
      if (m_pcnt == 4) begin
        s = (m_par[0] * 256 + m_par[1]) % (1 << COORD_W);
        e = (m_par[2] * 256 + m_par[3]) % (1 << COORD_W);
        if (e < s) e = s;
        if (m_mode == 1) begin m_sc = s; m_ec = e; end
        else begin m_sp = s; m_ep = e; end
        m_mode = 0;
      end
    end else if (m_mode == 3) begin
      if (m_have_hi == 0) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        w = m_ec - m_sc + 1;
        h = m_ep - m_sp + 1;
        x = m_sc + m_n % w;
        y = m_sp + (m_n / w) % h;
        exp_pix.push_back('{x, y, m_hi * 256 + b, int'(x == m_ec && y == m_ep)});
        m_n = (m_n + 1) % (w * h);
        m_have_hi = 0;
      end
    end
  endtask

  task automatic send_byte(input int isdata, input int b);
    logic [7:0] v;
    v = 8'(b);
    @(negedge clk);
    cs = 1'b0;
    dc = (isdata != 0);
    for (int i = 7; i >= 0; i--) begin
      mosi = v[i];
      #20 sck = 1'b1;
      #20 sck = 1'b0;
    end
    model_byte(isdata, b);
  endtask

  task automatic cs_gap();
    @(negedge clk);
    cs = 1'b1;
    #40;
  endtask

  task automatic send_pixel(input int p);
    send_byte(1, (p >> 8) & 'hFF);
    send_byte(1, p & 'hFF);
  endtask

  task automatic send_window(input int cmd, input int s, input int e);
    send_byte(0, cmd);
    send_byte(1, (s >> 8) & 'hFF);
    send_byte(1, s & 'hFF);
    send_byte(1, (e >> 8) & 'hFF);
    send_byte(1, e & 'hFF);
  endtask

  task automatic drain();
    repeat (10) @(negedge clk);
  endtask

  task automatic clear_q();
    obs_pix.delete(); exp_pix.delete(); obs_cmd.delete(); exp_cmd.delete();
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    rst = 1'b0; cs = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); mosi = 1'($urandom_range(0, 1)); sck = 1'b1;
      if (cmd_valid || pixel_valid || frame_done) pulses++;
      @(negedge clk); sck = 1'b0;
      if (cmd_valid || pixel_valid || frame_done) pulses++;
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL reset_pulses got %0d want 0", pulses); end
    total++;
    if ({cmd_code, pixel_data, 7'(pixel_x), 7'(pixel_y)} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got code=%h data=%h x=%0d y=%0d want zeros",
               cmd_code, pixel_data, pixel_x, pixel_y);
    end
    @(negedge clk); cs = 1'b1; rst = 1'b1;
    model_reset(); clear_q();
    send_byte(0, 'h2C);
    send_pixel('h1234);
    drain();
    total++;
    if (obs_pix.size() != 1 || obs_pix[0] != '{0, 0, 'h1234, 0}) begin
      bad++;
      $display("FAIL reset_first_pixel got n=%0d want one pixel (0,0) 1234", obs_pix.size());
    end
  endtask

  task automatic test_partial_byte();
    clear_q();
    @(negedge clk); cs = 1'b0; dc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1; #20 sck = 1'b1; #20 sck = 1'b0;
    end
    cs_gap();
    send_byte(0, 'h2C);
    drain();
    total++;
    if (cmd_code !== 8'h2C) begin bad++; $display("FAIL partial_code got %h want 2c", cmd_code); end
    total++;
    if (obs_cmd.size() != 1 || obs_pix.size() != 0) begin
      bad++;
      $display("FAIL partial_stray got cmds=%0d pix=%0d want 1 and 0", obs_cmd.size(), obs_pix.size());
    end
  endtask

  task automatic test_aborted_caset();
    clear_q();
    send_byte(0, 'h2A); send_byte(1, 'h00); send_byte(1, 'h0A);
    send_byte(0, 'h2C);
    send_pixel('hBEEF);
    drain();
    total++;
    if (obs_pix.size() != 1 || obs_pix[0].x != 0 || obs_pix[0].y != 0) begin
      bad++;
      $display("FAIL aborted_caset got n=%0d x=%0d want pixel at (0,0)",
               obs_pix.size(), obs_pix.size() > 0 ? obs_pix[0].x : -1);
    end
    total++;
    if (obs_pix != exp_pix) begin bad++; $display("FAIL aborted_caset_model got pix=%0d want %0d", obs_pix.size(), exp_pix.size()); end
  endtask

  task automatic test_window_stream();
    int colors[7] = '{'hF800, 'h07E0, 'h001F, 'hFFFF, 'h0000, 'hFFE0, 'h780F};
    int ex[7] = '{5, 6, 7, 5, 6, 7, 5};
    int ey[7] = '{2, 2, 2, 3, 3, 3, 2};
    clear_q();
    send_window('h2A, 5, 7);
    send_window('h2B, 2, 3);
    send_byte(0, 'h2C);
    foreach (colors[i]) send_pixel(colors[i]);
    drain();
    total++;
    if (obs_pix.size() != 7) begin bad++; $display("FAIL win_count got %0d want 7", obs_pix.size()); end
    for (int i = 0; i < 7 && i < obs_pix.size(); i++) begin
      total++;
      if (obs_pix[i] != '{ex[i], ey[i], colors[i], int'(i == 5)}) begin
        bad++;
        $display("FAIL win_pix%0d got (%0d,%0d) %h fd=%0d want (%0d,%0d) %h fd=%0d", i,
                 obs_pix[i].x, obs_pix[i].y, obs_pix[i].d, obs_pix[i].fd,
                 ex[i], ey[i], colors[i], int'(i == 5));
      end
    end
    total++;
    if (obs_cmd != '{'h2A, 'h2B, 'h2C}) begin
      bad++; $display("FAIL win_cmds got n=%0d want 2a,2b,2c", obs_cmd.size());
    end
  endtask

  task automatic test_reversed_window();
    clear_q();
    send_window('h2A, 9, 4);
    send_window('h2B, 0, 0);
    send_byte(0, 'h2C);
    send_pixel('h1111);
    send_pixel('h2222);
    drain();
    total++;
    if (obs_pix.size() != 2) begin bad++; $display("FAIL rev_count got %0d want 2", obs_pix.size()); end
    for (int i = 0; i < obs_pix.size() && i < 2; i++) begin
      total++;
      if (obs_pix[i].x != 9 || obs_pix[i].y != 0 || obs_pix[i].fd != 1) begin
        bad++;
        $display("FAIL rev_pix%0d got (%0d,%0d) fd=%0d want (9,0) fd=1", i,
                 obs_pix[i].x, obs_pix[i].y, obs_pix[i].fd);
      end
    end
  endtask

  task automatic test_random_stream();
    int s, e, n;
    for (int r = 0; r < 4; r++) begin
      clear_q();
      if ($urandom_range(0, 1) == 1) begin send_byte(0, 'h11); send_byte(1, $urandom_range(0, 255)); end
      for (int k = 0; k < 2; k++) begin
        s = $urandom_range(0, 1023);
        e = ($urandom_range(0, 4) == 0) ? ((s + 'hFFFF) & 'hFFFF) : s + $urandom_range(0, 3);
        send_byte(0, k == 0 ? 'h2A : 'h2B);
        send_byte(1, (s >> 8) & 'hFF);
        if ($urandom_range(0, 2) == 0) cs_gap();
        send_byte(1, s & 'hFF);
        send_byte(1, (e >> 8) & 'hFF);
        send_byte(1, e & 'hFF);
      end
      send_byte(0, 'h2C);
      n = $urandom_range(1, 10);
      for (int p = 0; p < n; p++) begin
        send_byte(1, $urandom_range(0, 255));
        if ($urandom_range(0, 2) == 0) cs_gap();
        send_byte(1, $urandom_range(0, 255));
      end
      drain();
      total++;
      if (obs_pix.size() != exp_pix.size()) begin
        bad++; $display("FAIL rand%0d_count got %0d want %0d", r, obs_pix.size(), exp_pix.size());
      end
      for (int i = 0; i < exp_pix.size() && i < obs_pix.size(); i++) begin
        total++;
        if (obs_pix[i] != exp_pix[i]) begin
          bad++;
          $display("FAIL rand%0d_pix%0d got (%0d,%0d) %h fd=%0d want (%0d,%0d) %h fd=%0d", r, i,
                   obs_pix[i].x, obs_pix[i].y, obs_pix[i].d, obs_pix[i].fd,
                   exp_pix[i].x, exp_pix[i].y, exp_pix[i].d, exp_pix[i].fd);
        end
      end
      total++;
      if (obs_cmd != exp_cmd) begin
        bad++; $display("FAIL rand%0d_cmds got n=%0d want %0d", r, obs_cmd.size(), exp_cmd.size());
      end
    end
  endtask

  task automatic test_latency();
    int first;
    first = -1;
    clear_q();
    @(negedge clk); cs = 1'b0; dc = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mosi = 1'b0; #20 sck = 1'b1; #20 sck = 1'b0;
    end
    @(negedge clk); mosi = 1'b0;
    @(posedge clk); #1 sck = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (cmd_valid && first < 0) first = k;
    end
    @(negedge clk); sck = 1'b0;
    model_byte(0, 'h00);
    drain();
    total++;
    if (first != SYNC + 2) begin bad++; $display("FAIL latency got %0d want %0d", first, SYNC + 2); end
    total++;
    if (obs_cmd != exp_cmd) begin bad++; $display("FAIL latency_cmd got n=%0d want 1 nop", obs_cmd.size()); end
  endtask

  task automatic test_async_reset();
    clear_q();
    send_byte(0, 'h2C);
    send_byte(1, 'hAB);
    drain();
    @(negedge clk); #2 rst = 1'b0;
    #1;
    total++;
    if (cmd_valid || pixel_valid || frame_done) begin
      bad++; $display("FAIL areset_pulses got %b%b%b want 000", cmd_valid, pixel_valid, frame_done);
    end
    total++;
    if (cmd_code !== 8'h00 || pixel_data !== 16'h0 || pixel_x !== '0 || pixel_y !== '0) begin
      bad++;
      $display("FAIL areset_outputs got code=%h data=%h x=%0d y=%0d want zeros",
               cmd_code, pixel_data, pixel_x, pixel_y);
    end
    @(negedge clk); rst = 1'b1;
    model_reset(); clear_q();
    send_byte(1, 'hCD);
    drain();
    total++;
    if (obs_pix.size() != 0) begin bad++; $display("FAIL areset_orphan got %0d pixels want 0", obs_pix.size()); end
    send_byte(0, 'h2C);
    for (int p = 0; p < HRES + 1; p++) send_pixel($urandom_range(0, 'hFFFF));
    drain();
    total++;
    if (obs_pix != exp_pix) begin
      bad++; $display("FAIL areset_stream got n=%0d want %0d matching", obs_pix.size(), exp_pix.size());
    end
    total++;
    if (obs_pix.size() != HRES + 1 || obs_pix[HRES].x != 0 || obs_pix[HRES].y != 1 ||
        obs_pix[HRES - 1].x != HRES - 1) begin
      bad++; $display("FAIL areset_default_wrap got n=%0d want wrap to (0,1) after x=%0d",
                      obs_pix.size(), HRES - 1);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_partial_byte();
    test_aborted_caset();
    test_window_stream();
    test_reversed_window();
    test_random_stream();
    test_latency();
    test_async_reset();
    total++;
    if (collisions != 0 || stray_fd != 0) begin
      bad++; $display("FAIL pulse_rules got collisions=%0d stray_fd=%0d want 0", collisions, stray_fd);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout got no finish want finish");
    $fatal(1);
  end

endmodule
